// File: rtl/ins_memory_boot.sv
// ins_memory_boot
//   Instruction memory with a boot-load front end. After reset the block is
//   in LOAD and takes a program stream over a valid/ready loader port, one
//   word per transfer, starting at word 0. A word flagged ld_last, or the
//   word that fills the last slot, moves the block to RUN. In RUN it serves
//   registered fetches from a byte-addressed PC with one cycle of latency.
//   Each result is flagged as ok, misaligned, or unloaded/out of range.
//   A reload request in RUN sends the block back to LOAD for a new program.
//
// Ports
//   clk        in   single clock, all logic on posedge
//   RST        in   synchronous active-low reset
//   ld_valid   in   loader word valid
//   ld_data    in   loader word (DataWidth)
//   ld_last    in   final word of the program
//   ld_ready   out  loader may transfer (LOAD state, not in reset)
//   reload     in   RUN only: restart loading from word 0
//   fetch_en   in   fetch request this cycle
//   PC         in   fetch byte address (AddrWidth)
//   REData     out  fetched instruction, registered (DataWidth)
//   ins_valid  out  REData/fault valid this cycle
//   fault      out  00 ok, 01 misaligned, 10 unloaded/out of range
//   boot_done  out  high in RUN state
module ins_memory_boot #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int Depth     = 256
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 ld_valid,
    input  logic [DataWidth-1:0] ld_data,
    input  logic                 ld_last,
    output logic                 ld_ready,
    input  logic                 reload,
    input  logic                 fetch_en,
    input  logic [AddrWidth-1:0] PC,
    output logic [DataWidth-1:0] REData,
    output logic                 ins_valid,
    output logic [1:0]           fault,
    output logic                 boot_done
);

    localparam int Bytes = DataWidth / 8;
    localparam int OffW  = $clog2(Bytes);
    localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int LcW   = $clog2(Depth + 1);

    localparam logic [1:0] FaultOk    = 2'b00;
    localparam logic [1:0] FaultAlign = 2'b01;
    localparam logic [1:0] FaultRange = 2'b10;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DataWidth-1:0] mem [Depth];

    logic [PtrW-1:0]      ld_ptr;
    logic [LcW-1:0]       load_count;

    logic                 xfer;
    logic                 ptr_at_end;
    logic                 fetch_go;
    logic [AddrWidth-1:0] idx;
    logic                 misaligned;
    logic                 in_range;
    logic [PtrW-1:0]      rd_idx;

    // ------------------------------------------------------------------
    // Loader handshake
    // ------------------------------------------------------------------
    // RST is folded into ld_ready so that a word offered while reset is
    // held low is never written, even though the array itself has no reset.
    assign ld_ready   = (state == LOAD) & RST;
    assign boot_done  = (state == RUN);
    assign xfer       = ld_valid & ld_ready;
    assign ptr_at_end = (ld_ptr == PtrW'(Depth - 1));

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!RST) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                // Filling the last slot ends the load, so the loader does not
                // need to send ld_last for a full-size program.
                if (xfer && (ld_last || ptr_at_end)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Load pointer and loaded-word count
    // ------------------------------------------------------------------
    // load_count is one bit wider than ld_ptr so a full load reads Depth.
    // The pointer returns to 0 when it leaves the last slot; it is cleared
    // again by reload or reset before the next program in any case.
    always_ff @(posedge clk) begin
        if (!RST) begin
            ld_ptr     <= '0;
            load_count <= '0;
        end else if (state == RUN && reload) begin
            ld_ptr     <= '0;
            load_count <= '0;
        end else if (xfer) begin
            ld_ptr     <= ptr_at_end ? '0 : ld_ptr + PtrW'(1);
            load_count <= LcW'(ld_ptr) + LcW'(1);
        end
    end

    // Storage is left uninitialised by reset on purpose: the program is
    // made unreachable logically through load_count instead.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[ld_ptr] <= ld_data;
        end
    end

    // ------------------------------------------------------------------
    // Fetch decode
    // ------------------------------------------------------------------
    assign idx = PC >> OffW;

    generate
        if (OffW > 0) begin : g_align
            assign misaligned = |PC[OffW-1:0];
        end else begin : g_noalign
            assign misaligned = 1'b0;
        end
    endgenerate

    // Compare at a common width so neither side is truncated.
    assign in_range = ({{LcW{1'b0}}, idx} < {{AddrWidth{1'b0}}, load_count});
    assign rd_idx   = PtrW'(idx);

    // A reload in the same cycle as a fetch takes precedence; the fetch
    // is dropped.
    assign fetch_go = (state == RUN) & ~reload & fetch_en;

    // ------------------------------------------------------------------
    // Registered fetch result
    // ------------------------------------------------------------------
    // REData and fault only update on an accepted fetch. Otherwise they
    // hold their last values while ins_valid drops.
    always_ff @(posedge clk) begin
        if (!RST) begin
            REData    <= '0;
            ins_valid <= 1'b0;
            fault     <= FaultOk;
        end else if (fetch_go) begin
            ins_valid <= 1'b1;
            if (misaligned) begin
                fault  <= FaultAlign;
                REData <= '0;
            end else if (!in_range) begin
                fault  <= FaultRange;
                REData <= '0;
            end else begin
                fault  <= FaultOk;
                REData <= mem[rd_idx];
            end
        end else begin
            ins_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ins_memory_boot.sv
// Directed bench for ins_memory_boot.
// Instance dut uses Depth=8 and is used for ld_last loads, fetches, faults,
// reload, and reset mid-load.
// Instance dut4 uses Depth=4 and is used for an auto-terminated full load.
module tb_ins_memory_boot;

    logic        clk;
    logic        RST;

    logic        ld_valid, ld_last, reload, fetch_en;
    logic [31:0] ld_data, PC;
    logic        ld_ready, ins_valid, boot_done;
    logic [31:0] REData;
    logic [1:0]  fault;

    logic        ld_valid4, ld_last4, reload4, fetch_en4;
    logic [31:0] ld_data4, PC4;
    logic        ld_ready4, ins_valid4, boot_done4;
    logic [31:0] REData4;
    logic [1:0]  fault4;

    int checks   = 0;
    int failures = 0;

    logic [31:0] A [4] = '{32'h1111_00A0, 32'h2222_00A1, 32'h3333_00A2, 32'h4444_00A3};
    logic [31:0] W [5] = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004};
    logic [31:0] B [2] = '{32'hBBBB_0000, 32'hBBBB_0001};

    ins_memory_boot #(.DataWidth(32), .AddrWidth(32), .Depth(8)) dut (
        .clk(clk), .RST(RST),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .reload(reload), .fetch_en(fetch_en), .PC(PC),
        .REData(REData), .ins_valid(ins_valid), .fault(fault), .boot_done(boot_done)
    );

    ins_memory_boot #(.DataWidth(32), .AddrWidth(32), .Depth(4)) dut4 (
        .clk(clk), .RST(RST),
        .ld_valid(ld_valid4), .ld_data(ld_data4), .ld_last(ld_last4), .ld_ready(ld_ready4),
        .reload(reload4), .fetch_en(fetch_en4), .PC(PC4),
        .REData(REData4), .ins_valid(ins_valid4), .fault(fault4), .boot_done(boot_done4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one posedge, then settle 1 time unit so sampled outputs are
    // away from the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        cyc();
        cyc();
        checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL rst_iv got=%b exp=0", ins_valid); end
        checks++; if (REData !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", REData); end
        checks++; if (fault !== 2'b00) begin failures++; $display("FAIL rst_fault got=%b exp=00", fault); end
        checks++; if (boot_done !== 1'b0) begin failures++; $display("FAIL rst_boot got=%b exp=0", boot_done); end
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_in_rst got=%b exp=0", ld_ready); end
        RST = 1'b1;
        #1;
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", ld_ready); end
    endtask

    task automatic test_load();
        fetch_en = 1'b1;
        PC = 32'h0;
        ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_data = A[i];
            ld_last = (i == 3);
            #1;
            checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL load_ready[%0d] got=%b exp=1", i, ld_ready); end
            cyc();
            if (i < 3) begin
                checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL load_fetch_ignored[%0d] got=%b exp=0", i, ins_valid); end
            end
        end
        ld_valid = 1'b0;
        ld_last = 1'b0;
        fetch_en = 1'b0;
        #1;
        checks++; if (boot_done !== 1'b1) begin failures++; $display("FAIL load_boot got=%b exp=1", boot_done); end
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL load_ready_drop got=%b exp=0", ld_ready); end
    endtask

    task automatic test_back_to_back();
        fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            PC = 32'(i * 4);
            cyc();
            checks++; if (ins_valid !== 1'b1) begin failures++; $display("FAIL b2b_iv[%0d] got=%b exp=1", i, ins_valid); end
            checks++; if (REData !== A[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, REData, A[i]); end
            checks++; if (fault !== 2'b00) begin failures++; $display("FAIL b2b_fault[%0d] got=%b exp=00", i, fault); end
        end
        fetch_en = 1'b0;
        PC = 32'h0;
        cyc();
        checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL idle_iv got=%b exp=0", ins_valid); end
        checks++; if (REData !== A[3]) begin failures++; $display("FAIL idle_hold got=%h exp=%h", REData, A[3]); end
    endtask

    task automatic test_faults();
        logic [31:0] pcs  [5] = '{32'd6, 32'd16, 32'd18, 32'd3, 32'd12};
        logic [1:0]  fexp [5] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b00};
        logic [31:0] dexp [5];
        dexp = '{32'h0, 32'h0, 32'h0, 32'h0, A[3]};
        fetch_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            PC = pcs[i];
            cyc();
            checks++; if (fault !== fexp[i] || ins_valid !== 1'b1) begin failures++; $display("FAIL fault_pc%0d got=%b/%b exp=%b/1", pcs[i], fault, ins_valid, fexp[i]); end
            checks++; if (REData !== dexp[i]) begin failures++; $display("FAIL fault_data_pc%0d got=%h exp=%h", pcs[i], REData, dexp[i]); end
        end
        fetch_en = 1'b0;
        cyc();
    endtask

    task automatic test_full_depth();
        ld_valid4 = 1'b1;
        ld_last4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_data4 = W[i];
            #1;
            checks++; if (ld_ready4 !== (i < 4)) begin failures++; $display("FAIL full_ready[%0d] got=%b exp=%b", i, ld_ready4, (i < 4)); end
            cyc();
            if (i == 3) begin
                checks++; if (boot_done4 !== 1'b1) begin failures++; $display("FAIL full_boot got=%b exp=1", boot_done4); end
            end
        end
        ld_valid4 = 1'b0;
        fetch_en4 = 1'b1;
        PC4 = 32'd12;
        cyc();
        checks++; if (REData4 !== W[3] || fault4 !== 2'b00) begin failures++; $display("FAIL full_pc12 got=%h/%b exp=%h/00", REData4, fault4, W[3]); end
        PC4 = 32'd0;
        cyc();
        checks++; if (REData4 !== W[0]) begin failures++; $display("FAIL full_pc0 got=%h exp=%h", REData4, W[0]); end
        PC4 = 32'd16;
        cyc();
        checks++; if (REData4 !== 32'h0 || fault4 !== 2'b10) begin failures++; $display("FAIL full_pc16 got=%h/%b exp=0/10", REData4, fault4); end
        fetch_en4 = 1'b0;
        cyc();
    endtask

    task automatic test_reload();
        fetch_en = 1'b1;
        PC = 32'd0;
        cyc();
        checks++; if (ins_valid !== 1'b1) begin failures++; $display("FAIL reload_pre_iv got=%b exp=1", ins_valid); end
        reload = 1'b1;
        PC = 32'd4;
        cyc();
        reload = 1'b0;
        #1;
        checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL reload_iv got=%b exp=0", ins_valid); end
        checks++; if (boot_done !== 1'b0 || ld_ready !== 1'b1) begin failures++; $display("FAIL reload_state got=%b/%b exp=0/1", boot_done, ld_ready); end
        PC = 32'd0;
        cyc();
        checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL reload_fetch_ignored got=%b exp=0", ins_valid); end
        ld_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ld_data = B[i];
            ld_last = (i == 1);
            cyc();
        end
        ld_valid = 1'b0;
        ld_last = 1'b0;
        checks++; if (boot_done !== 1'b1) begin failures++; $display("FAIL reload_boot got=%b exp=1", boot_done); end
        PC = 32'd4;
        cyc();
        checks++; if (REData !== B[1] || fault !== 2'b00) begin failures++; $display("FAIL reload_pc4 got=%h/%b exp=%h/00", REData, fault, B[1]); end
        PC = 32'd8;
        cyc();
        checks++; if (REData !== 32'h0 || fault !== 2'b10) begin failures++; $display("FAIL reload_pc8 got=%h/%b exp=0/10", REData, fault); end
        PC = 32'd0;
        cyc();
        checks++; if (REData !== B[0]) begin failures++; $display("FAIL reload_pc0 got=%h exp=%h", REData, B[0]); end
        fetch_en = 1'b0;
    endtask

    task automatic test_reset_midload();
        reload = 1'b1;
        cyc();
        reload = 1'b0;
        ld_valid = 1'b1;
        ld_data = 32'hC0C0_0000;
        cyc();
        ld_data = 32'hC0C0_0001;
        cyc();
        RST = 1'b0;
        ld_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_in_rst got=%b exp=0", ld_ready); end
        cyc();
        checks++; if (boot_done !== 1'b0 || ins_valid !== 1'b0) begin failures++; $display("FAIL mid_ctrl got=%b/%b exp=0/0", boot_done, ins_valid); end
        checks++; if (REData !== 32'h0 || fault !== 2'b00) begin failures++; $display("FAIL mid_out got=%h/%b exp=0/00", REData, fault); end
        RST = 1'b1;
        ld_data = 32'hD0D0_0000;
        ld_last = 1'b1;
        #1;
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", ld_ready); end
        cyc();
        ld_valid = 1'b0;
        ld_last = 1'b0;
        fetch_en = 1'b1;
        PC = 32'd0;
        cyc();
        checks++; if (REData !== 32'hD0D0_0000 || fault !== 2'b00) begin failures++; $display("FAIL mid_pc0 got=%h/%b exp=d0d00000/00", REData, fault); end
        PC = 32'd4;
        cyc();
        checks++; if (REData !== 32'h0 || fault !== 2'b10) begin failures++; $display("FAIL mid_pc4 got=%h/%b exp=0/10", REData, fault); end
        fetch_en = 1'b0;
        cyc();
    endtask

    initial begin
        RST = 1'b0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; reload = 1'b0; fetch_en = 1'b0; PC = '0;
        ld_valid4 = 1'b0; ld_data4 = '0; ld_last4 = 1'b0; reload4 = 1'b0; fetch_en4 = 1'b0; PC4 = '0;
        test_reset();
        test_load();
        test_back_to_back();
        test_faults();
        test_full_depth();
        test_reload();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
